// File: rtl/instr_seq_ctrl.sv
// Fetch/decode sequencer: owns PC and IR, fetches over a req/ack port, resolves
// branch and halt locally and hands every other instruction to the datapath.
module instr_seq_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic [15:0]     ir,
    output logic            dp_start,
    input  logic            dp_done,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_WAIT_DP = 3'd4;
    localparam logic [2:0] ST_HALT    = 3'd5;

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Branch target pc + 1 + sext(imm8), computed wide and truncated so it wraps both ways.
    function automatic logic [PC_W-1:0] branch_target(
        input logic [PC_W-1:0] base,
        input logic [7:0]      imm
    );
        logic [PC_W+7:0] base_x;
        logic [PC_W+7:0] imm_x;
        logic [PC_W+7:0] sum_x;
        base_x = {8'h00, base};
        imm_x  = {{PC_W{imm[7]}}, imm};
        sum_x  = base_x + imm_x + {{(PC_W+7){1'b0}}, 1'b1};
        return sum_x[PC_W-1:0];
    endfunction

    logic [2:0]      state_r,    state_s;
    logic [PC_W-1:0] pc_r,       pc_s;
    logic [15:0]     ir_r,       ir_s;
    logic            mem_req_r,  mem_req_s;
    logic [PC_W-1:0] mem_addr_r, mem_addr_s;
    logic            dp_start_r, dp_start_s;
    logic            halted_r,   halted_s;
    logic [PC_W-1:0] br_target_s;
    logic [PC_W-1:0] pc_inc_s;

    assign br_target_s = branch_target(pc_r, ir_r[7:0]);
    assign pc_inc_s    = pc_r + PC_ONE;

    // Next-state and next-output logic; every output is the registered copy of these.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        dp_start_s = 1'b0;
        halted_s   = halted_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s    = ST_FETCH;
                    mem_req_s  = 1'b1;
                    mem_addr_s = pc_r;
                end else begin
                    mem_req_s  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_s      = mem_rdata;
                    mem_req_s = 1'b0;
                    state_s   = ST_DECODE;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            ST_DECODE: begin
                case (ir_r[15:13])
                    OP_HALT: begin
                        halted_s = 1'b1;
                        state_s  = ST_HALT;
                    end
                    OP_BRANCH: begin
                        pc_s       = br_target_s;
                        mem_addr_s = br_target_s;
                        mem_req_s  = 1'b1;
                        state_s    = ST_FETCH;
                    end
                    default: begin
                        dp_start_s = 1'b1;
                        state_s    = ST_EXEC;
                    end
                endcase
            end
            ST_EXEC: begin
                state_s = ST_WAIT_DP;
            end
            ST_WAIT_DP: begin
                if (dp_done) begin
                    pc_s       = pc_inc_s;
                    mem_addr_s = pc_inc_s;
                    mem_req_s  = 1'b1;
                    state_s    = ST_FETCH;
                end else begin
                    state_s    = ST_WAIT_DP;
                end
            end
            ST_HALT: begin
                mem_req_s = 1'b0;
                state_s   = ST_HALT;
            end
            default: begin
                // Unreachable encodings fall back to a quiet IDLE.
                mem_req_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any coincident ack or done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            ir_r       <= 16'h0000;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
            dp_start_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            dp_start_r <= dp_start_s;
            halted_r   <= halted_s;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign ir       = ir_r;
    assign dp_start = dp_start_r;
    assign pc       = pc_r;
    assign halted   = halted_r;

endmodule
